// File: rtl/buffer_desempaquetador_pixeles.sv
// Word FIFO feeding an output stage that unpacks each 32-bit memory word into
// four 8-bit pixels, least-significant byte first, streaming gap-free when data allows.
module buffer_desempaquetador_pixeles #(
    parameter int PROFUNDIDAD    = 8,
    parameter int BITS_OCUPACION = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      limpiar,
    input  logic                      save_mem_data,
    input  logic [31:0]               mem_data,
    input  logic                      leer_pixel,
    output logic                      buf_space_available,
    output logic [7:0]                pixel,
    output logic                      pixel_valido,
    output logic [BITS_OCUPACION-1:0] ocupacion,
    output logic                      desbordamiento
);

    localparam int BITS_PTR = $clog2(PROFUNDIDAD);
    localparam logic [BITS_OCUPACION-1:0] OCUP_MAX = BITS_OCUPACION'(PROFUNDIDAD);

    typedef enum logic {E_VACIO, E_ENTREGA} estado_t;

    logic [31:0]               memoria_q [PROFUNDIDAD];
    logic [BITS_PTR-1:0]       ptrEsc_q, ptrEsc_d;
    logic [BITS_PTR-1:0]       ptrLec_q, ptrLec_d;
    logic [BITS_OCUPACION-1:0] ocupacion_q, ocupacion_d;
    estado_t                   estado_q, estado_d;
    logic [1:0]                indice_q, indice_d;
    logic [31:0]               palabra_q, palabra_d;
    logic                      desb_q, desb_d;
    logic                      hayDatos, lleno, pop, push;

    always_comb begin
        hayDatos    = (ocupacion_q != '0);
        lleno       = (ocupacion_q == OCUP_MAX);
        estado_d    = estado_q;
        indice_d    = indice_q;
        palabra_d   = palabra_q;
        pop         = 1'b0;

        case (estado_q)
            E_VACIO: begin
                if (hayDatos) begin
                    pop      = 1'b1;
                    estado_d = E_ENTREGA;
                    indice_d = 2'd0;
                end
            end
            E_ENTREGA: begin
                if (leer_pixel) begin
                    if (indice_q != 2'd3) begin
                        indice_d = indice_q + 2'd1;
                    end else if (hayDatos) begin
                        pop      = 1'b1;
                        indice_d = 2'd0;
                    end else begin
                        estado_d = E_VACIO;
                        indice_d = 2'd0;
                    end
                end
            end
            default: estado_d = E_VACIO;
        endcase

        if (pop) begin
            palabra_d = memoria_q[ptrLec_q];
        end

        // A pop on the same edge frees the slot, so a full FIFO still takes the write.
        push        = save_mem_data && (!lleno || pop);
        desb_d      = desb_q || (save_mem_data && lleno && !pop);
        ptrEsc_d    = push ? ptrEsc_q + 1'b1 : ptrEsc_q;
        ptrLec_d    = pop  ? ptrLec_q + 1'b1 : ptrLec_q;
        ocupacion_d = ocupacion_q;
        if (push && !pop) begin
            ocupacion_d = ocupacion_q + 1'b1;
        end else if (pop && !push) begin
            ocupacion_d = ocupacion_q - 1'b1;
        end

        if (limpiar) begin
            push        = 1'b0;
            ptrEsc_d    = '0;
            ptrLec_d    = '0;
            ocupacion_d = '0;
            estado_d    = E_VACIO;
            indice_d    = 2'd0;
            desb_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptrEsc_q    <= '0;
            ptrLec_q    <= '0;
            ocupacion_q <= '0;
            estado_q    <= E_VACIO;
            indice_q    <= 2'd0;
            palabra_q   <= '0;
            desb_q      <= 1'b0;
        end else begin
            ptrEsc_q    <= ptrEsc_d;
            ptrLec_q    <= ptrLec_d;
            ocupacion_q <= ocupacion_d;
            estado_q    <= estado_d;
            indice_q    <= indice_d;
            palabra_q   <= palabra_d;
            desb_q      <= desb_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            memoria_q[ptrEsc_q] <= mem_data;
        end
    end

    assign buf_space_available = (ocupacion_q < OCUP_MAX);
    assign pixel_valido        = (estado_q == E_ENTREGA);
    assign pixel               = palabra_q[{indice_q, 3'b000} +: 8];
    assign ocupacion           = ocupacion_q;
    assign desbordamiento      = desb_q;

endmodule

// File: doc/buffer_desempaquetador_pixeles.md
BUFFER_DESEMPAQUETADOR_PIXELES -- requirements
Module: buffer_desempaquetador_pixeles

Interface
REQ-001 SHALL have parameter PROFUNDIDAD, default 8: FIFO depth in 32-bit words, power of two, at least 2.
REQ-002 SHALL have parameter BITS_OCUPACION, default 4: width of the occupancy count, equal to log2(PROFUNDIDAD)+1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port limpiar, input, 1 bit: synchronous flush of all buffered data.
REQ-006 SHALL have port save_mem_data, input, 1 bit: one-cycle strobe meaning mem_data holds a valid word.
REQ-007 SHALL have port mem_data, input, 32 bits: word read from external memory.
REQ-008 SHALL have port leer_pixel, input, 1 bit: window stage consumes the presented pixel.
REQ-009 SHALL have port buf_space_available, output, 1 bit: at least one free word slot.
REQ-010 SHALL have port pixel, output, 8 bits: pixel currently presented.
REQ-011 SHALL have port pixel_valido, output, 1 bit: pixel holds valid data.
REQ-012 SHALL have port ocupacion, output, BITS_OCUPACION bits: number of words stored in the FIFO, excluding the word in the output stage.
REQ-013 SHALL have port desbordamiento, output, 1 bit: sticky flag set when a write occurs while the FIFO is full.

Function
REQ-014 SHALL store the word on mem_data in the FIFO on each edge where save_mem_data=1 and ocupacion<PROFUNDIDAD.
REQ-015 SHALL, when save_mem_data=1 and ocupacion=PROFUNDIDAD, discard the word, leave the FIFO unchanged and set desbordamiento=1.
REQ-016 SHALL drive buf_space_available = (ocupacion < PROFUNDIDAD) combinationally from registered state, so it reflects a write on the cycle after that write.
REQ-017 SHALL use an output stage with states E_VACIO (no word held) and E_ENTREGA (word held, byte index 0..3).
REQ-018 SHALL move from E_VACIO to E_ENTREGA on any edge where ocupacion>0: pop the FIFO head into the output word and set the index to 0.
REQ-019 SHALL never let a word written on edge N load into the output stage before edge N+1, so the latency from write strobe to pixel_valido is at least 2 cycles.
REQ-020 SHALL assert pixel_valido = (state==E_ENTREGA) and drive pixel with byte[index] of the held word, least-significant byte first (index 0 = bits 7:0).
REQ-021 SHALL ignore leer_pixel while pixel_valido=0.
REQ-022 SHALL, on leer_pixel=1 in E_ENTREGA with index<3, increment the index.
REQ-023 SHALL, on leer_pixel=1 in E_ENTREGA with index=3 and ocupacion>0, pop the next word and set the index to 0 in the same edge, so pixels stream gap-free.
REQ-024 SHALL, on leer_pixel=1 in E_ENTREGA with index=3 and ocupacion=0, return to E_VACIO.
REQ-025 SHALL, when a push and a pop occur on the same edge, leave ocupacion unchanged and keep the data order.
REQ-026 SHALL, when full, allow a pop and a push on the same edge; the push is accepted and does not count as an overflow.
REQ-027 SHALL use read and write pointers of log2(PROFUNDIDAD) bits that wrap modulo PROFUNDIDAD.
REQ-028 SHALL, on limpiar=1, clear the pointers, ocupacion and index, enter E_VACIO and clear desbordamiento; a simultaneous save_mem_data is discarded.
REQ-029 SHALL never output X on pixel; the held word resets to 0.

Reset
REQ-030 SHALL, on any edge with reset=0, regardless of other inputs, reach: ocupacion=0, pointers=0, state E_VACIO, index=0, held word=0, desbordamiento=0.
REQ-031 SHALL therefore present after reset: buf_space_available=1, pixel_valido=0, pixel=8'h00.
REQ-032 SHALL, when reset is asserted mid-stream, discard all buffered data with no partial pixel emitted afterwards.
REQ-033 SHALL not require reset to initialise FIFO storage contents.

Verification
REQ-034 Single word: write 32'hDDCCBBAA with leer_pixel held at 1 -> pixel_valido high from write+2, pixels AA, BB, CC, DD on consecutive cycles, then pixel_valido=0.
REQ-035 Fill: PROFUNDIDAD+1 consecutive writes with leer_pixel=0 -> first word moves to the output stage and ocupacion reaches 8, buf_space_available=0 after the full condition; one further write -> desbordamiento=1 and data order is unchanged on readout.
REQ-036 Streaming: writes every 4 cycles with leer_pixel=1 continuously -> a gap-free pixel sequence that matches the bytes in order, and ocupacion stays at 0 or 1.
REQ-037 Pointer wrap: 3*PROFUNDIDAD words with random leer_pixel (about 50%) -> output matches a scoreboard and desbordamiento remains 0 while writes are gated by buf_space_available.
REQ-038 Flush and reset mid-stream: 3 words buffered, limpiar=1 on one cycle -> next cycle pixel_valido=0, ocupacion=0; repeat with reset=0 -> same result and pixel=8'h00.
REQ-039 Simultaneous push/pop at full: at ocupacion=8, index=3, apply leer_pixel=1 and save_mem_data=1 on the same edge -> ocupacion stays 8, desbordamiento=0, and the new word is read out last.
